// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Instruction FIFO between the fetch stage and the decoder.
//               Each entry carries {pred_jump, pc, inst}. Fetch pushes at most
//               one entry per cycle. Decode pops the head through a
//               valid/ready handshake, and the head is presented
//               combinationally (first-word fall-through). full_to_if asserts
//               early, leaving FULL_MARGIN slots free for a push that fetch
//               has already committed to. rollback_flag empties the queue.
//               overflow_err is sticky and is cleared only by rst.
// Ports       : clk, rst (sync, active-high), rdy (global enable)
//               fetch side  : push_flag_from_if, inst_from_if, pc_from_if,
//                             pred_jump_from_if, full_to_if
//               decode side : valid_to_dec, inst_to_dec, pc_to_dec,
//                             pred_jump_to_dec, dec_ready
//               control     : rollback_flag, overflow_err
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        push_flag_from_if,
    input  logic [31:0] inst_from_if,
    input  logic [31:0] pc_from_if,
    input  logic        pred_jump_from_if,
    output logic        full_to_if,
    output logic        valid_to_dec,
    output logic [31:0] inst_to_dec,
    output logic [31:0] pc_to_dec,
    output logic        pred_jump_to_dec,
    input  logic        dec_ready,
    input  logic        rollback_flag,
    output logic        overflow_err
);

    localparam int               c_ENTRY_W     = 65;
    localparam logic [PTR_W:0]   c_DEPTH       = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_FULL_THRESH = (PTR_W+1)'(DEPTH - FULL_MARGIN);
    localparam logic [PTR_W-1:0] c_PTR_ONE     = PTR_W'(1);

    // Storage is never reset: contents are only observed when count != 0.
    logic [c_ENTRY_W-1:0] r_mem_q [DEPTH];

    logic [PTR_W-1:0] r_head_q, w_head_d;
    logic [PTR_W-1:0] r_tail_q, w_tail_d;
    logic [PTR_W:0]   r_count_q, w_count_d;
    logic             r_overflow_q, w_overflow_d;

    logic             w_pop;
    logic             w_push_acc;
    logic             w_push_drop;
    logic             w_wr_en;
    logic [c_ENTRY_W-1:0] w_entry;

    assign w_entry = {pred_jump_from_if, pc_from_if, inst_from_if};

    // Head/status outputs depend only on registered state.
    assign valid_to_dec = (r_count_q != '0);
    assign full_to_if   = (r_count_q >= c_FULL_THRESH);
    assign overflow_err = r_overflow_q;
    assign {pred_jump_to_dec, pc_to_dec, inst_to_dec} = r_mem_q[r_head_q];

    always_comb begin
        w_pop        = valid_to_dec && dec_ready;
        // A full queue still accepts a push when the head leaves in the
        // same cycle: the freed slot is the one the tail is pointing at.
        w_push_acc   = push_flag_from_if && ((r_count_q < c_DEPTH) || w_pop);
        w_push_drop  = push_flag_from_if && !w_push_acc;

        w_head_d     = r_head_q;
        w_tail_d     = r_tail_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        w_wr_en      = 1'b0;

        if (rdy) begin
            if (rollback_flag) begin
                // Flush wins over any push/pop this cycle; the sticky error
                // bit is deliberately left alone.
                w_head_d  = '0;
                w_tail_d  = '0;
                w_count_d = '0;
            end else begin
                if (w_pop) begin
                    w_head_d = r_head_q + c_PTR_ONE;
                end
                if (w_push_acc) begin
                    w_tail_d = r_tail_q + c_PTR_ONE;
                    w_wr_en  = !rst;
                end
                if (w_push_drop) begin
                    w_overflow_d = 1'b1;
                end
                w_count_d = r_count_q + (PTR_W+1)'(w_push_acc) - (PTR_W+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q     <= '0;
            r_tail_q     <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
        end else begin
            r_head_q     <= w_head_d;
            r_tail_q     <= w_tail_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_q[r_tail_q] <= w_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_queue
// Description : Self-checking bench for inst_queue. A queue-based model of the
//               FIFO is updated on every rising edge and compared with the DUT
//               on every falling edge. Directed scenarios add literal
//               expectations; a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        push_flag_from_if;
    logic [31:0] inst_from_if;
    logic [31:0] pc_from_if;
    logic        pred_jump_from_if;
    logic        full_to_if;
    logic        valid_to_dec;
    logic [31:0] inst_to_dec;
    logic [31:0] pc_to_dec;
    logic        pred_jump_to_dec;
    logic        dec_ready;
    logic        rollback_flag;
    logic        overflow_err;

    inst_queue #(.DEPTH(16), .PTR_W(4), .FULL_MARGIN(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .push_flag_from_if (push_flag_from_if),
        .inst_from_if      (inst_from_if),
        .pc_from_if        (pc_from_if),
        .pred_jump_from_if (pred_jump_from_if),
        .full_to_if        (full_to_if),
        .valid_to_dec      (valid_to_dec),
        .inst_to_dec       (inst_to_dec),
        .pc_to_dec         (pc_to_dec),
        .pred_jump_to_dec  (pred_jump_to_dec),
        .dec_ready         (dec_ready),
        .rollback_flag     (rollback_flag),
        .overflow_err      (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [64:0] mq[$];
    bit          m_ovf = 1'b0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO semantics on a plain queue.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (rdy) begin
            if (rollback_flag) begin
                mq.delete();
            end else begin
                do_pop  = (mq.size() != 0) && dec_ready;
                do_push = push_flag_from_if && (mq.size() < DEPTH || do_pop);
                if (push_flag_from_if && !do_push) m_ovf = 1'b1;
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back({pred_jump_from_if, pc_from_if, inst_from_if});
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_to_dec", valid_to_dec, (mq.size() != 0));
            check("full_to_if", full_to_if, (mq.size() >= DEPTH - 2));
            check("overflow_err", overflow_err, m_ovf);
            if (mq.size() != 0)
                check("head_entry", {pred_jump_to_dec, pc_to_dec, inst_to_dec}, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        push_flag_from_if = 1'b0;
        dec_ready         = 1'b0;
        rollback_flag     = 1'b0;
        rdy               = 1'b1;
        rst               = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_entry(input logic [31:0] inst, input logic [31:0] pc, input logic pj);
        inst_from_if      = inst;
        pc_from_if        = pc;
        pred_jump_from_if = pj;
    endtask

    initial begin
        logic [31:0] first_inst;
        logic [31:0] second_inst;
        logic [31:0] held_pc;
        int sent;
        int got;
        int guard;

        idle_inputs();
        set_entry(32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // 1: reset state, then four pushes with the decoder stalled
        check("reset_valid", valid_to_dec, 1'b0);
        check("reset_full", full_to_if, 1'b0);
        check("reset_ovf", overflow_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_flag_from_if = 1'b1;
            set_entry(32'hA000_0000 + i, 32'h100 + 4 * i, i[0]);
            tick();
            if (i == 0) begin
                check("t1_valid_after_1", valid_to_dec, 1'b1);
                check("t1_head_A0", inst_to_dec, 32'hA000_0000);
            end
        end
        push_flag_from_if = 1'b0;
        check("t1_model_count", mq.size(), 4);
        check("t1_head_still_A0", pc_to_dec, 32'h100);

        // 2: fill up, almost-full threshold, overflow
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_flag_from_if = 1'b1;
            set_entry(32'hC000_0000 + i, 32'h2000 + 4 * i, 1'b1);
            tick();
            if (i == 12) check("t2_full_at_13", full_to_if, 1'b0);
            if (i == 13) check("t2_full_at_14", full_to_if, 1'b1);
            if (i == 15) check("t2_ovf_at_16", overflow_err, 1'b0);
        end
        push_flag_from_if = 1'b0;
        first_inst  = 32'hC000_0000;
        second_inst = 32'hC000_0001;
        check("t2_ovf_set", overflow_err, 1'b1);
        check("t2_head_unchanged", inst_to_dec, first_inst);

        // 3: full queue, simultaneous push and pop
        push_flag_from_if = 1'b1;
        dec_ready         = 1'b1;
        set_entry(32'hD00D_0000, 32'h3000, 1'b0);
        tick();
        push_flag_from_if = 1'b0;
        dec_ready         = 1'b0;
        check("t3_count_16", mq.size(), 16);
        check("t3_full", full_to_if, 1'b1);
        check("t3_head_next", inst_to_dec, second_inst);
        dec_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("t3_tail_entry", inst_to_dec, 32'hD00D_0000);
        tick();
        check("t3_drained", valid_to_dec, 1'b0);

        // 4: 40-entry stream with toggling dec_ready across the wrap
        do_reset();
        sent = 0;
        got  = 0;
        guard = 0;
        while ((sent < 40 || got < 40) && guard < 500) begin
            dec_ready = guard[0];
            push_flag_from_if = (sent < 40) && !full_to_if;
            set_entry($urandom, 32'h1000 + 4 * sent, 1'($urandom));
            if (valid_to_dec && dec_ready) begin
                check("t4_stream_pc", pc_to_dec, 32'h1000 + 4 * got);
                got++;
            end
            if (push_flag_from_if) sent++;
            tick();
            guard++;
        end
        idle_inputs();
        check("t4_received_40", got, 40);
        check("t4_no_ovf", overflow_err, 1'b0);

        // 5: rollback with concurrent push and pop
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push_flag_from_if = 1'b1;
            set_entry(32'hE000_0000 + i, 32'h4000 + 4 * i, 1'b0);
            tick();
        end
        rollback_flag = 1'b1;
        dec_ready     = 1'b1;
        set_entry(32'hEEEE_EEEE, 32'h4FFF_0000, 1'b1);
        tick();
        rollback_flag = 1'b0;
        dec_ready     = 1'b0;
        check("t5_flushed", valid_to_dec, 1'b0);
        set_entry(32'hB0B0_B0B0, 32'h0000_B000, 1'b1);
        tick();
        push_flag_from_if = 1'b0;
        check("t5_B0_valid", valid_to_dec, 1'b1);
        check("t5_B0_pc", pc_to_dec, 32'h0000_B000);

        // 6: rdy hold, then reset mid-stream clears overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_flag_from_if = 1'b1;
            set_entry(32'hF000_0000 + i, 32'h5000 + 4 * i, 1'b0);
            tick();
        end
        held_pc   = 32'h5000;
        rdy       = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold_pc", pc_to_dec, held_pc);
            check("t6_hold_valid", valid_to_dec, 1'b1);
        end
        check("t6_model_count", mq.size(), 5);
        rdy       = 1'b1;
        dec_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push_flag_from_if = 1'b1;
            set_entry(32'hF100_0000 + i, 32'h6000 + 4 * i, 1'b1);
            tick();
        end
        check("t6_ovf_before_rst", overflow_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_flag_from_if = 1'b0;
        check("t6_rst_valid", valid_to_dec, 1'b0);
        check("t6_rst_ovf", overflow_err, 1'b0);
        check("t6_rst_full", full_to_if, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            push_flag_from_if = ($urandom_range(0, 99) < 60) && (!full_to_if || $urandom_range(0, 9) == 0);
            dec_ready         = ($urandom_range(0, 99) < 45);
            rollback_flag     = ($urandom_range(0, 99) < 2);
            rdy               = ($urandom_range(0, 99) < 90);
            rst               = ($urandom_range(0, 999) < 3);
            set_entry($urandom, $urandom, 1'($urandom));
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
